mem_port_arbiter: RTL

Parametrised N-channel arbiter and response router for the single cache request port (`cache_req_*` / `cache_rsp_*`) at the top of the core. It replaces the fixed single-requester path so the core load/store unit, the bootloader data loader and future requesters (second core, DMA) share the cache without external muxing. Arbitration is round-robin, with one registered request stage toward the cache. Read responses return to the issuing channel in order through a tag FIFO that tracks up to DEPTH outstanding reads.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of channel-side and cache-side signals around the memory port arbiter.
// The arbiter takes the master modport; requesters and the cache sit on slave.
interface mem_port_arbiter_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [N_CH-1:0]        req_valid;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH*ADDR_W-1:0] req_addr;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH-1:0]        req_wr;
    logic [N_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic [ADDR_W-1:0]      cache_req_addr;
    logic [DATA_W-1:0]      cache_req_data;
    logic                   cache_req_wr;
    logic                   cache_req_valid;
    logic                   cache_req_ready;
    logic [DATA_W-1:0]      cache_rsp_data;
    logic                   cache_rsp_valid;
    logic [CNT_W-1:0]       outstanding;
    logic                   rsp_orphan;

    modport master (
        input  req_valid, req_addr, req_data, req_wr,
        input  cache_req_ready, cache_rsp_data, cache_rsp_valid,
        output req_ready, rsp_valid, rsp_data,
        output cache_req_addr, cache_req_data, cache_req_wr, cache_req_valid,
        output outstanding, rsp_orphan
    );

    modport slave (
        output req_valid, req_addr, req_data, req_wr,
        output cache_req_ready, cache_rsp_data, cache_rsp_valid,
        input  req_ready, rsp_valid, rsp_data,
        input  cache_req_addr, cache_req_data, cache_req_wr, cache_req_valid,
        input  outstanding, rsp_orphan
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin N-channel arbiter onto one registered cache request port, with
// in-order read-response routing through a tag FIFO of issuing channel indices.
module mem_port_arbiter #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned TAG_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic              valid_q;
    logic [TAG_W-1:0]  rr_ptr_q;
    logic [TAG_W-1:0]  tag_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [N_CH-1:0]   rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              orphan_q;

    logic              stage_free;
    logic              fifo_full;
    logic              fifo_empty;
    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   grant;
    logic              gnt_any;
    logic [TAG_W-1:0]  gnt_idx;
    logic [TAG_W-1:0]  rr_ptr_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_wr;
    logic              push;
    logic              pop;
    logic [TAG_W-1:0]  head;
    logic [N_CH-1:0]   rsp_valid_d;

    assign stage_free = !valid_q || bus.cache_req_ready;
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    // Fullness uses the registered count, so a same-cycle pop never unblocks a read.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = bus.req_valid[i] && (!bus.req_wr[i] || !fifo_full);
        end
    end

    // Two passes: channels at or above rr_ptr first, then the wrapped-around rest.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (stage_free && !reset) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!gnt_any && eligible[i] && (TAG_W'(i) >= rr_ptr_q)) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = TAG_W'(i);
                    grant[i] = 1'b1;
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                if (!gnt_any && eligible[i]) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = TAG_W'(i);
                    grant[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
                sel_wr   = bus.req_wr[i];
            end
        end
    end

    assign rr_ptr_d = (gnt_idx == TAG_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    assign push     = |(grant & bus.req_wr);
    assign pop      = bus.cache_rsp_valid && !fifo_empty;

    always_comb begin
        rsp_valid_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            rsp_valid_d[i] = pop && (head == TAG_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b1;
            valid_q     <= 1'b0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            orphan_q    <= 1'b0;
        end else begin
            if (gnt_any) begin
                addr_q   <= sel_addr;
                data_q   <= sel_data;
                wr_q     <= sel_wr;
                valid_q  <= 1'b1;
                rr_ptr_q <= rr_ptr_d;
            end else if (bus.cache_req_ready) begin
                valid_q <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                rsp_data_q <= bus.cache_rsp_data;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            rsp_valid_q <= rsp_valid_d;
            if (bus.cache_rsp_valid && fifo_empty) begin
                orphan_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign bus.req_ready       = grant;
    assign bus.cache_req_addr  = addr_q;
    assign bus.cache_req_data  = data_q;
    assign bus.cache_req_wr    = wr_q;
    assign bus.cache_req_valid = valid_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.outstanding     = count_q;
    assign bus.rsp_orphan      = orphan_q;
endmodule
